cascade_dispatch: RTL and testbench
===================================

CASCADE_DISPATCH -- requirements
Module: cascade_dispatch

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of cascade engines driven; legal range 2..8.
REQ-002 SHALL have parameter ID_W, default 16, width of window identifier.
REQ-003 SHALL have parameter CNT_W, default 16, width of face counter.
REQ-004 SHALL have port clk_i  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port win_val_i  input  1  window descriptor valid.
REQ-007 SHALL have port win_id_i  input  ID_W  window identifier.
REQ-008 SHALL have port win_vnf_i  input  32  variance_norm_factor of the window.
REQ-009 SHALL have port win_rdy_o  output  1  descriptor accepted when win_val_i & win_rdy_o.
REQ-010 SHALL have port eng_start_o  output  NUM_CH  one-cycle start pulse per engine.
REQ-011 SHALL have port eng_vnf_o  output  NUM_CH*32  per-engine variance_norm_factor, slice k = bits [32k+31:32k].
REQ-012 SHALL have port eng_done_i  input  NUM_CH  per-engine done pulse.
REQ-013 SHALL have port eng_result_i  input  NUM_CH  per-engine result, sampled with eng_done_i.
REQ-014 SHALL have port res_val_o  output  1  result valid.
REQ-015 SHALL have port res_id_o  output  ID_W  identifier of retired window.
REQ-016 SHALL have port res_face_o  output  1  1 = window passed all stages.
REQ-017 SHALL have port res_rdy_i  input  1  downstream accepts result.
REQ-018 SHALL have port busy_o  output  1  any engine not IDLE.
REQ-019 SHALL have port face_cnt_o  output  CNT_W  count of retired faces.

Function
REQ-020 SHALL keep per-engine state IDLE/RUN/HOLD plus registered id, vnf, result.
REQ-021 SHALL drive win_rdy_o = 1 iff at least one engine is IDLE, from registered state only.
REQ-022 SHALL on accept assign lowest-index IDLE engine k, store id/vnf, move k to RUN, push k into an in-order dispatch queue of depth NUM_CH.
REQ-023 SHALL assert eng_start_o[k] for exactly the cycle after accept; eng_vnf_o slice k SHALL hold stored vnf stable from that cycle until k returns to IDLE.
REQ-024 SHALL move engine k RUN->HOLD on eng_done_i[k], latching eng_result_i[k]; eng_done_i[k] SHALL be ignored when k is not RUN or in its start-pulse cycle.
REQ-025 SHALL retire strictly in dispatch order: res_val_o = 1 iff queue non-empty and head engine is HOLD; res_id_o/res_face_o from head engine.
REQ-026 SHALL hold res_val_o, res_id_o, res_face_o stable while res_val_o & !res_rdy_i.
REQ-027 SHALL on res_val_o & res_rdy_i pop queue, return head engine to IDLE next cycle, increment face_cnt_o if res_face_o.
REQ-028 SHALL saturate face_cnt_o at all-ones.
REQ-029 SHALL not re-dispatch an engine in the cycle it retires; it becomes eligible the following cycle.
REQ-030 SHALL allow accept and retire in the same cycle; queue push and pop then occur together with count unchanged.
REQ-031 SHALL never overflow the queue, since accept requires an IDLE engine.
REQ-032 SHALL drive busy_o = OR over engines of (state != IDLE), registered.

Reset
REQ-033 SHALL on rst_ni low asynchronously set all engines IDLE, queue empty, eng_start_o = 0, eng_vnf_o = 0, res_val_o = 0, res_id_o = 0, res_face_o = 0, face_cnt_o = 0, busy_o = 0, win_rdy_o = 1 after release.
REQ-034 SHALL discard in-flight windows on reset mid-operation; eng_done_i arriving after release SHALL be ignored.

Verification
REQ-035 Single window id=0x0005, vnf=0x100, engine done after 10 cycles result=1 -> eng_start_o=0001 one cycle after accept, res_val_o with id 0x0005 face 1, face_cnt_o=1.
REQ-036 Four windows back-to-back (NUM_CH=4), done order 3,1,0,2 -> win_rdy_o low after fourth accept, results retire in ids order 0,1,2,3.
REQ-037 res_rdy_i held low 20 cycles with res_val_o high -> outputs stable, no further retire, win_rdy_o stays low when all engines HOLD.
REQ-038 Spurious eng_done_i[2] while engine 2 IDLE -> no state change, no result.
REQ-039 face_cnt_o preloaded near max via 0xFFFF faces (CNT_W=16) then one more face -> face_cnt_o stays 0xFFFF.
REQ-040 rst_ni pulsed low with 3 engines RUN -> all outputs reset values immediately, later eng_done_i ignored, res_val_o stays 0.

Source files
------------

// File: rtl/cascade_dispatch.sv
// Window dispatcher feeding NUM_CH cascade engines.
// Results retire strictly in dispatch order via an engine-index FIFO.
module cascade_dispatch #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 win_val_i,
  input  logic [ID_W-1:0]      win_id_i,
  input  logic [31:0]          win_vnf_i,
  output logic                 win_rdy_o,
  output logic [NUM_CH-1:0]    eng_start_o,
  output logic [NUM_CH*32-1:0] eng_vnf_o,
  input  logic [NUM_CH-1:0]    eng_done_i,
  input  logic [NUM_CH-1:0]    eng_result_i,
  output logic                 res_val_o,
  output logic [ID_W-1:0]      res_id_o,
  output logic                 res_face_o,
  input  logic                 res_rdy_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     face_cnt_o
);

  localparam int IW = $clog2(NUM_CH);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } st_e;

  st_e               st_q [NUM_CH];
  st_e               st_d [NUM_CH];
  logic [ID_W-1:0]   id_q [NUM_CH];
  logic [31:0]       vnf_q [NUM_CH];
  logic [IW-1:0]     fifo_q [NUM_CH];
  logic [NUM_CH-1:0] res_q;
  logic [NUM_CH-1:0] start_q, start_d;
  logic [IW-1:0]     head_q, tail_q;
  logic [CW-1:0]     cnt_q;
  logic [CNT_W-1:0]  face_q;

  logic [NUM_CH-1:0] idle;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     hd;
  logic              acc, pop;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Lowest-index idle engine wins the next window.
  always_comb begin
    idle = '0;
    sel  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idle[k] = (st_q[k] == IDLE);
      if (st_q[k] == IDLE) sel = IW'(k);
    end
  end

  assign hd  = fifo_q[head_q];
  assign acc = win_val_i & win_rdy_o;
  assign pop = res_val_o & res_rdy_i;

  always_comb begin
    win_rdy_o   = |idle;
    busy_o      = ~&idle;
    res_val_o   = (cnt_q != '0) && (st_q[hd] == HOLD);
    res_id_o    = id_q[hd];
    res_face_o  = res_q[hd];
    eng_start_o = start_q;
    face_cnt_o  = face_q;
    eng_vnf_o   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      eng_vnf_o[32*k +: 32] = vnf_q[k];
    end
  end

  // Done is only honoured once the start pulse has gone out.
  always_comb begin
    start_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      st_d[k] = st_q[k];
      case (st_q[k])
        IDLE: if (acc && sel == IW'(k)) begin
          st_d[k]    = RUN;
          start_d[k] = 1'b1;
        end
        RUN:  if (eng_done_i[k] && !start_q[k]) st_d[k] = HOLD;
        HOLD: if (pop && hd == IW'(k)) st_d[k] = IDLE;
        default: st_d[k] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CH; k++) st_q[k] <= IDLE;
      start_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) st_q[k] <= st_d[k];
      start_q <= start_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CH; k++) begin
        id_q[k]   <= '0;
        vnf_q[k]  <= '0;
        fifo_q[k] <= '0;
      end
      res_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      face_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (start_d[k]) begin
          id_q[k]  <= win_id_i;
          vnf_q[k] <= win_vnf_i;
        end
        if (st_q[k] == RUN && st_d[k] == HOLD) res_q[k] <= eng_result_i[k];
      end
      if (acc) begin
        fifo_q[tail_q] <= sel;
        tail_q         <= nxt(tail_q);
      end
      if (pop) head_q <= nxt(head_q);
      case ({acc, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (pop && res_face_o && face_q != '1) face_q <= face_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cascade_dispatch.sv
// Bench for cascade_dispatch: engine model driven by vnf fields,
// in-order scoreboard on the result port, table-driven windows.
module tb_cascade_dispatch;

  localparam int N   = 4;
  localparam int IDW = 16;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           win_val = 1'b0;
  logic [IDW-1:0] win_id = '0;
  logic [31:0]    win_vnf = '0;
  logic           win_rdy_o;
  logic [N-1:0]   eng_start_o;
  logic [N*32-1:0] eng_vnf_o;
  logic [N-1:0]   mdone = '0;
  logic [N-1:0]   mres = '0;
  logic [N-1:0]   spur = '0;
  logic [N-1:0]   eng_done;
  logic           res_val_o;
  logic [IDW-1:0] res_id_o;
  logic           res_face_o;
  logic           res_rdy = 1'b1;
  logic           busy_o;
  logic [CW-1:0]  face_cnt_o;

  assign eng_done = mdone | spur;

  cascade_dispatch #(.NUM_CH(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .win_val_i(win_val), .win_id_i(win_id), .win_vnf_i(win_vnf),
    .win_rdy_o(win_rdy_o),
    .eng_start_o(eng_start_o), .eng_vnf_o(eng_vnf_o),
    .eng_done_i(eng_done), .eng_result_i(mres),
    .res_val_o(res_val_o), .res_id_o(res_id_o), .res_face_o(res_face_o),
    .res_rdy_i(res_rdy), .busy_o(busy_o), .face_cnt_o(face_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] id;
    logic [7:0]  dly;
    logic        face;
  } vec_t;

  typedef struct {
    logic [15:0] id;
    logic        face;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Engine model: delay in vnf[11:4], result in vnf[0]; ignores reset
  // on purpose so stale dones arrive after a mid-run reset.
  initial begin
    int   cd[N];
    logic act[N];
    logic rr[N];
    logic [31:0] v;
    for (int k = 0; k < N; k++) begin
      cd[k] = 0; act[k] = 1'b0; rr[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      mdone = '0;
      for (int k = 0; k < N; k++) begin
        if (eng_start_o[k]) begin
          v = eng_vnf_o[32*k +: 32];
          cd[k] = int'(v[11:4]);
          rr[k] = v[0];
          act[k] = 1'b1;
        end else if (act[k]) begin
          cd[k]--;
          if (cd[k] <= 0) begin
            mdone[k] = 1'b1;
            mres[k]  = rr[k];
            act[k]   = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard: compare every handshake against dispatch order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_val_o && res_rdy) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id %0h expected none",
                   res_id_o);
        end else begin
          e = sbq.pop_front();
          chk("ret_id", 64'(res_id_o), 64'(e.id));
          chk("ret_face", 64'(res_face_o), 64'(e.face));
          if (e.face && exp_cnt < SAT) exp_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] id, input logic [7:0] dly,
                      input logic face);
    int n = 0;
    bit ok = 0;
    win_val = 1'b1;
    win_id  = id;
    win_vnf = {20'h0, dly, 3'b000, face};
    while (!ok && n < 100) begin
      @(negedge clk);
      if (win_rdy_o) begin
        sbq.push_back('{id, face});
        ok = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    win_val = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept id %0h", id);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
    chk("face_cnt", 64'(face_cnt_o), 64'(exp_cnt));
    chk("idle_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    vec_t tab[8];
    tab[0] = '{16'h0010, 8'd12, 1'b1};
    tab[1] = '{16'h0011, 8'd8,  1'b0};
    tab[2] = '{16'h0012, 8'd16, 1'b1};
    tab[3] = '{16'h0013, 8'd4,  1'b1};
    tab[4] = '{16'h0020, 8'd2,  1'b1};
    tab[5] = '{16'h0021, 8'd3,  1'b1};
    tab[6] = '{16'h0022, 8'd2,  1'b0};
    tab[7] = '{16'h0023, 8'd4,  1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_val", 64'(res_val_o), 64'd0);
    chk("rst_start", 64'(eng_start_o), 64'd0);
    chk("rst_vnf", 64'(eng_vnf_o[63:0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rdy", 64'(win_rdy_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_cnt", 64'(face_cnt_o), 64'd0);
    chk("rst_id", 64'(res_id_o), 64'd0);

    // single window
    send(16'h0005, 8'd10, 1'b1);
    chk("start_pulse", 64'(eng_start_o), 64'h1);
    chk("start_vnf", 64'(eng_vnf_o[31:0]), 64'h0A1);
    @(posedge clk);
    #1;
    chk("start_one_cycle", 64'(eng_start_o), 64'h0);
    chk("vnf_stable", 64'(eng_vnf_o[31:0]), 64'h0A1);
    drain();

    // four back-to-back, done order 3,1,0,2
    for (int i = 0; i < 4; i++) send(tab[i].id, tab[i].dly, tab[i].face);
    chk("start_eng3", 64'(eng_start_o), 64'h8);
    chk("full_rdy", 64'(win_rdy_o), 64'd0);
    chk("full_busy", 64'(busy_o), 64'd1);
    drain();

    // backpressure with all engines holding
    res_rdy = 1'b0;
    for (int i = 4; i < 8; i++) send(tab[i].id, tab[i].dly, tab[i].face);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 20; c++) begin
      chk("stall_val", 64'(res_val_o), 64'd1);
      chk("stall_id", 64'(res_id_o), 64'(sbq[0].id));
      chk("stall_face", 64'(res_face_o), 64'(sbq[0].face));
      chk("stall_rdy", 64'(win_rdy_o), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("stall_cnt", 64'(face_cnt_o), 64'(exp_cnt));
    res_rdy = 1'b1;
    drain();

    // spurious done on idle engine 2
    spur = 4'b0100;
    @(posedge clk);
    #1;
    spur = '0;
    for (int c = 0; c < 3; c++) begin
      chk("spur_val", 64'(res_val_o), 64'd0);
      chk("spur_busy", 64'(busy_o), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("spur_rdy", 64'(win_rdy_o), 64'd1);

    // face counter saturation, streaming accept/retire overlap
    for (int i = 0; i < 12; i++) send(16'h0100 + 16'(i), 8'd2, 1'b1);
    drain();
    chk("sat_cnt", 64'(face_cnt_o), 64'(SAT));

    // reset with three engines running
    for (int i = 0; i < 3; i++) send(16'h0200 + 16'(i), 8'd30, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_cnt", 64'(face_cnt_o), 64'd0);
    chk("arst_vnf", 64'(eng_vnf_o[63:0]), 64'd0);
    chk("arst_start", 64'(eng_start_o), 64'd0);
    chk("arst_val", 64'(res_val_o), 64'd0);
    sbq.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_val", 64'(res_val_o), 64'd0);
    end
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    chk("post_rst_rdy", 64'(win_rdy_o), 64'd1);
    chk("post_rst_cnt", 64'(face_cnt_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
